receiver: RTL and testbench

UART receive path, the counterpart of the team's UART transmitter. It recovers 11-bit frames from the serial line: start bit 0, 8 data bits LSB first, even-parity bit, stop bit 1. It presents each received byte with a one-cycle done strobe plus parity and framing status. It runs on the system clock and oversamples the line, so it tolerates an asynchronous serial input.

---
 rtl/uart_pkg.sv | 14 +
 rtl/fsm_rx.sv | 71 +++++++
 rtl/receiver.sv | 70 +++++++
 tb/tb_receiver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame bit levels and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/fsm_rx.sv
// Receive sequencer: tracks frame position with a bit-period counter and data index,
// and raises one-cycle enables at each mid-bit sample point.
module fsm_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_s,
  input  logic rx_d,
  output logic shift_en,
  output logic parity_en,
  output logic done_en,
  output logic busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST = 3'(DATA_BITS - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             bit_end;

  assign bit_end = (cnt == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        // Requires a genuine high-to-low edge, so a line stuck low never restarts
        IDLE: if (rx_d == STOP_BIT && rx_s == START_BIT) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (cnt == HALF) begin
          cnt   <= '0;
          state <= (rx_s == START_BIT) ? DATA : IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        DATA: if (bit_end) begin
          cnt <= '0;
          idx <= idx + 3'd1;
          if (idx == LAST) state <= PARITY;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        PARITY, STOP: if (bit_end) begin
          cnt   <= '0;
          state <= (state == PARITY) ? STOP : IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign shift_en  = (state == DATA)   && bit_end;
  assign parity_en = (state == PARITY) && bit_end;
  assign done_en   = (state == STOP)   && bit_end;
  assign busy      = (state != IDLE);

endmodule

// File: rtl/receiver.sv
// UART receiver: synchronizes the serial line, assembles 8N-parity-1 frames and
// reports each byte with a one-cycle done strobe plus parity/framing status.
module receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_Rxdatain,
  output logic [7:0] o_dataout,
  output logic       o_Rxdone,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  logic                 sync1, rx_s, rx_d;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 shift_en, parity_en, done_en, busy;

  // Sync chain resets to the idle level so reset release never looks like a start edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= i_Rxdatain;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  fsm_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_fsm (
    .clk       (i_clk),
    .rst       (i_reset),
    .rx_s      (rx_s),
    .rx_d      (rx_d),
    .shift_en  (shift_en),
    .parity_en (parity_en),
    .done_en   (done_en),
    .busy      (busy)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      o_dataout    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_Rxdone     <= 1'b0;
    end else begin
      o_Rxdone <= done_en;
      if (shift_en)  shift_reg  <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (parity_en) parity_bit <= rx_s;
      if (done_en) begin
        o_dataout    <= shift_reg;
        o_parity_err <= (parity_bit != parity_of(shift_reg, PARITY_ODD));
        o_frame_err  <= (rx_s != STOP_BIT);
      end
    end
  end

  assign o_busy = busy;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: frames are queued as expectations when driven and
// checked by a negedge monitor whenever o_Rxdone pulses.
module tb_receiver;

  localparam int CPB = 8;
  localparam int LAT = 3 + CPB/2 + 10*CPB;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_Rxdatain;
  logic [7:0] o_dataout;
  logic       o_Rxdone, o_parity_err, o_frame_err, o_busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   done_cycs[$];
  int   cyc = 0;
  int   done_count = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_done = 1'b0;

  receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_Rxdatain   (i_Rxdatain),
    .o_dataout    (o_dataout),
    .o_Rxdone     (o_Rxdone),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_Rxdone === 1'b1) begin
      exp_t e;
      done_count++;
      done_cycs.push_back(cyc);
      check("done_one_cycle", {31'd0, prev_done}, 0);
      check("done_expected", {31'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dataout", {24'd0, o_dataout}, {24'd0, e.d});
        check("parity_err", {31'd0, o_parity_err}, {31'd0, e.pe});
        check("frame_err", {31'd0, o_frame_err}, {31'd0, e.fe});
        check("done_latency", cyc - e.start, LAT);
      end
    end
    prev_done = o_Rxdone;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered and left #1 after a rising edge so bit periods chain exactly
  task automatic hold(input logic b, input int n);
    i_Rxdatain = b;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    exp_t e;
    e.d = d; e.pe = (par != ^d); e.fe = ~stp; e.start = cyc;
    exp_q.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    hold(par, CPB);
    hold(stp, CPB);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge i_clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] saved_d;
    int         saved_dc;
    int         busy_cnt;

    i_reset = 1'b1;
    i_Rxdatain = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_dataout", {24'd0, o_dataout}, 0);
    check("rst_done", {31'd0, o_Rxdone}, 0);
    check("rst_perr", {31'd0, o_parity_err}, 0);
    check("rst_ferr", {31'd0, o_frame_err}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    i_reset = 1'b0;
    hold(1'b1, 5);

    send_frame(8'hA5, 1'b0, 1'b1);
    drain("a5_drain");
    hold(1'b1, 4);
    check("a5_busy_after", {31'd0, o_busy}, 0);

    send_frame(8'h01, 1'b0, 1'b1);
    drain("bad_parity_drain");
    hold(1'b1, 4);

    // Framing error with the line left low: exactly one strobe, no restart while low
    saved_dc = done_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 20);
    check("ferr_single_done", done_count, saved_dc + 1);
    check("ferr_idle_low", {31'd0, o_busy}, 0);
    hold(1'b1, CPB);
    send_frame(8'h5A, 1'b0, 1'b1);
    drain("after_ferr_drain");
    hold(1'b1, 4);

    saved_d = o_dataout;
    saved_dc = done_count;
    busy_cnt = 0;
    hold(1'b0, 2);
    i_Rxdatain = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      busy_cnt += int'(o_busy);
    end
    check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 1);
    check("glitch_busy_short", {31'd0, busy_cnt <= 4}, 1);
    check("glitch_no_done", done_count, saved_dc);
    check("glitch_data_kept", {24'd0, o_dataout}, {24'd0, saved_d});
    @(posedge i_clk);
    #1;
    check("glitch_busy_end", {31'd0, o_busy}, 0);

    // Reset in the middle of the data bits of 0x55
    saved_dc = done_count;
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, 4);
    check("pre_rst_busy", {31'd0, o_busy}, 1);
    i_reset = 1'b1;
    #1;
    check("midrst_dataout", {24'd0, o_dataout}, 0);
    check("midrst_done", {31'd0, o_Rxdone}, 0);
    check("midrst_perr", {31'd0, o_parity_err}, 0);
    check("midrst_ferr", {31'd0, o_frame_err}, 0);
    check("midrst_busy", {31'd0, o_busy}, 0);
    i_Rxdatain = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    hold(1'b1, 2*CPB);
    check("midrst_no_done", done_count, saved_dc);
    send_frame(8'h55, 1'b0, 1'b1);
    drain("post_rst_drain");
    hold(1'b1, 4);

    done_cycs.delete();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    drain("b2b_drain");
    check("b2b_count", done_cycs.size(), 2);
    if (done_cycs.size() == 2)
      check("b2b_spacing", done_cycs[1] - done_cycs[0], 88);
    hold(1'b1, 4);
    check("b2b_busy_after", {31'd0, o_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
